// File: rtl/nbit_demux1x2_buffered.sv
// nbit_demux1x2_buffered
// Steers one N-bit source stream to destination A (in_sel=0) or B (in_sel=1).
// Each destination owns a 2-entry FIFO with valid/ready on both sides.
//
// Handshake: a beat moves across an interface on the rising clk edge where
// both valid and ready are high. The source must hold in_data/in_valid while
// in_ready is low (in_sel may change; the new select's readiness applies).
// in_ready depends only on the registered occupancy of the selected FIFO, so
// a full FIFO being popped in the same cycle still refuses the beat.
module nbit_demux1x2_buffered #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic         in_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] a_data,
    output logic         a_valid,
    input  logic         a_ready,
    output logic [1:0]   a_count,
    output logic [N-1:0] b_data,
    output logic         b_valid,
    input  logic         b_ready,
    output logic [1:0]   b_count
);

    // A FIFO storage and pointers
    logic [N-1:0] r_a_mem [2];
    logic         r_a_wr;
    logic         r_a_rd;
    logic [1:0]   r_a_cnt;

    // B FIFO storage and pointers
    logic [N-1:0] r_b_mem [2];
    logic         r_b_wr;
    logic         r_b_rd;
    logic [1:0]   r_b_cnt;

    logic w_a_has_room;
    logic w_b_has_room;
    logic w_push_a;
    logic w_push_b;
    logic w_pop_a;
    logic w_pop_b;

    // Readiness and transfer qualifiers, all from registered occupancy
    always_comb begin
        w_a_has_room = (r_a_cnt < 2'd2);
        w_b_has_room = (r_b_cnt < 2'd2);
        in_ready     = in_sel ? w_b_has_room : w_a_has_room;
        w_push_a     = in_valid && in_ready && !in_sel;
        w_push_b     = in_valid && in_ready &&  in_sel;
        w_pop_a      = a_valid && a_ready;
        w_pop_b      = b_valid && b_ready;
    end

    // Output views: head entry and non-empty flag of each FIFO
    always_comb begin
        a_data  = r_a_mem[r_a_rd];
        a_valid = (r_a_cnt != 2'd0);
        a_count = r_a_cnt;
        b_data  = r_b_mem[r_b_rd];
        b_valid = (r_b_cnt != 2'd0);
        b_count = r_b_cnt;
    end

    // A FIFO: write on push, advance read on pop, 1-bit pointers wrap 1 -> 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_mem[0] <= '0;
            r_a_mem[1] <= '0;
            r_a_wr     <= 1'b0;
            r_a_rd     <= 1'b0;
            r_a_cnt    <= 2'd0;
        end else begin
            if (w_push_a) begin
                r_a_mem[r_a_wr] <= in_data;
                r_a_wr          <= ~r_a_wr;
            end
            if (w_pop_a) begin
                r_a_rd <= ~r_a_rd;
            end
            if (w_push_a && !w_pop_a) begin
                r_a_cnt <= r_a_cnt + 2'd1;
            end else if (w_pop_a && !w_push_a) begin
                r_a_cnt <= r_a_cnt - 2'd1;
            end
        end
    end

    // B FIFO: same structure as A
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b_mem[0] <= '0;
            r_b_mem[1] <= '0;
            r_b_wr     <= 1'b0;
            r_b_rd     <= 1'b0;
            r_b_cnt    <= 2'd0;
        end else begin
            if (w_push_b) begin
                r_b_mem[r_b_wr] <= in_data;
                r_b_wr          <= ~r_b_wr;
            end
            if (w_pop_b) begin
                r_b_rd <= ~r_b_rd;
            end
            if (w_push_b && !w_pop_b) begin
                r_b_cnt <= r_b_cnt + 2'd1;
            end else if (w_pop_b && !w_push_b) begin
                r_b_cnt <= r_b_cnt - 2'd1;
            end
        end
    end

endmodule
